// File: rtl/perceptron_trainer_pkg.sv
// rtl/perceptron_trainer_pkg.sv - shared types and widths for the perceptron training sequencer
package perceptron_trainer_pkg;

    localparam int IN1_W   = 4;
    localparam int IN2_W   = 4;
    localparam int IN3_W   = 7;
    localparam int IDX_W   = 4;   // sample index, up to 16 samples
    localparam int CNT_W   = 5;   // sample count, 0..16
    localparam int EPOCH_W = 8;
    localparam int ERR_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_CHECK,
        ST_EPOCH_END,
        ST_DONE
    } trainer_state_t;

    typedef struct packed {
        logic [IN1_W-1:0] in1;
        logic [IN2_W-1:0] in2;
        logic [IN3_W-1:0] in3;
        logic             desired;
    } trainer_sample_t;

    // Address width for a memory of the given depth; never narrower than one bit.
    function automatic int mem_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/trainer_sample_mem.sv
// rtl/trainer_sample_mem.sv - sample register file, one write port, one asynchronous read port
module trainer_sample_mem
    import perceptron_trainer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = mem_addr_w(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  trainer_sample_t wdata,
    input  logic [AW-1:0]   raddr,
    output trainer_sample_t rdata
);

    // Sized to a power of two so every address value selects a real entry.
    trainer_sample_t mem_q [0:(1<<AW)-1];

    // Write port; contents are don't-care after reset, so no reset is applied.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - training sequencer feeding labelled samples to a perceptron; TRAINER_STATS_EN adds run statistics
module perceptron_trainer
    import perceptron_trainer_pkg::*;
#(
    parameter int NUM_SAMPLES   = 8,
    parameter int MAX_EPOCHS    = 64,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [IN1_W-1:0]   load_in1,
    input  logic [IN2_W-1:0]   load_in2,
    input  logic [IN3_W-1:0]   load_in3,
    input  logic               load_desired,
    input  logic               clear_samples,
    input  logic               start,
    output logic [IN1_W-1:0]   in1,
    output logic [IN2_W-1:0]   in2,
    output logic [IN3_W-1:0]   in3,
    output logic               desired_out,
    input  logic               perc_out,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic [EPOCH_W-1:0] epoch_count,
    output logic [ERR_W-1:0]   error_count
`ifdef TRAINER_STATS_EN
    ,
    output logic [15:0]        total_errors,
    output logic [ERR_W-1:0]   last_epoch_errors
`endif
);

    localparam int                 ADDR_W        = mem_addr_w(NUM_SAMPLES);
    localparam int                 HOLD_W        = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]   NUM_SAMPLES_C = CNT_W'(NUM_SAMPLES);
    localparam logic [EPOCH_W-1:0] MAX_EPOCHS_C  = EPOCH_W'(MAX_EPOCHS);
    localparam logic [HOLD_W-1:0]  HOLD_LAST_C   = HOLD_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX_C     = '1;

    trainer_state_t     state_q;
    logic [CNT_W-1:0]   sample_count_q;
    logic [IDX_W-1:0]   idx_q;
    logic [HOLD_W-1:0]  hold_q;
    trainer_sample_t    sample_q;
    logic               busy_q;
    logic               done_q;
    logic               converged_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic [ERR_W-1:0]   err_q;
`ifdef TRAINER_STATS_EN
    logic [15:0]        total_q;
    logic [ERR_W-1:0]   last_err_q;
`endif

    logic               idle_or_done;
    logic               mem_we;
    logic               start_fire;
    logic               mismatch;
    logic               last_sample;
    logic [EPOCH_W-1:0] epoch_next;
    logic [ADDR_W-1:0]  rd_addr;
    trainer_sample_t    wr_sample;
    trainer_sample_t    rd_sample;

    assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign load_ready   = idle_or_done && (sample_count_q < NUM_SAMPLES_C);
    // A clear in the same cycle drops the load and blocks a start, so a run never sees an empty memory.
    assign mem_we       = load_valid && load_ready && !clear_samples;
    assign start_fire   = idle_or_done && start && !clear_samples && (sample_count_q != '0);
    assign mismatch     = (perc_out != sample_q.desired);
    assign last_sample  = ({1'b0, idx_q} == (sample_count_q - CNT_W'(1)));
    assign epoch_next   = epoch_q + EPOCH_W'(1);
    // Read address is the sample about to be presented: the next one from CHECK, otherwise sample 0.
    assign rd_addr      = (state_q == ST_CHECK) ? (idx_q[ADDR_W-1:0] + ADDR_W'(1)) : '0;
    assign wr_sample    = '{in1: load_in1, in2: load_in2, in3: load_in3, desired: load_desired};

    trainer_sample_mem #(
        .DEPTH (NUM_SAMPLES),
        .AW    (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (sample_count_q[ADDR_W-1:0]),
        .wdata (wr_sample),
        .raddr (rd_addr),
        .rdata (rd_sample)
    );

    // Training FSM with sample loading, presentation, checking and epoch accounting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            sample_count_q <= '0;
            idx_q          <= '0;
            hold_q         <= '0;
            sample_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            converged_q    <= 1'b0;
            epoch_q        <= '0;
            err_q          <= '0;
`ifdef TRAINER_STATS_EN
            total_q        <= '0;
            last_err_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (clear_samples) begin
                        sample_count_q <= '0;
                    end else if (mem_we) begin
                        sample_count_q <= sample_count_q + CNT_W'(1);
                    end
                    if (start_fire) begin
                        state_q     <= ST_PRESENT;
                        idx_q       <= '0;
                        hold_q      <= '0;
                        sample_q    <= rd_sample;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        converged_q <= 1'b0;
                        epoch_q     <= '0;
                        err_q       <= '0;
`ifdef TRAINER_STATS_EN
                        total_q     <= '0;
`endif
                    end
                end
                ST_PRESENT: begin
                    if (hold_q == HOLD_LAST_C) begin
                        state_q <= ST_CHECK;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX_C) begin
                            err_q <= err_q + ERR_W'(1);
                        end
`ifdef TRAINER_STATS_EN
                        if (total_q != 16'hFFFF) begin
                            total_q <= total_q + 16'd1;
                        end
`endif
                    end
                    if (last_sample) begin
                        state_q <= ST_EPOCH_END;
                    end else begin
                        idx_q    <= idx_q + IDX_W'(1);
                        hold_q   <= '0;
                        sample_q <= rd_sample;
                        state_q  <= ST_PRESENT;
                    end
                end
                ST_EPOCH_END: begin
`ifdef TRAINER_STATS_EN
                    last_err_q <= err_q;
`endif
                    if (err_q == '0) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        converged_q <= 1'b1;
                    end else begin
                        epoch_q <= epoch_next;
                        if (epoch_next == MAX_EPOCHS_C) begin
                            state_q     <= ST_DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            converged_q <= 1'b0;
                        end else begin
                            err_q    <= '0;
                            idx_q    <= '0;
                            hold_q   <= '0;
                            sample_q <= rd_sample;
                            state_q  <= ST_PRESENT;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in1         = sample_q.in1;
    assign in2         = sample_q.in2;
    assign in3         = sample_q.in3;
    assign desired_out = sample_q.desired;
    assign busy        = busy_q;
    assign done        = done_q;
    assign converged   = converged_q;
    assign epoch_count = epoch_q;
    assign error_count = err_q;
`ifdef TRAINER_STATS_EN
    assign total_errors      = total_q;
    assign last_epoch_errors = last_err_q;
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - self-checking bench for perceptron_trainer with a behavioural run model
module tb_perceptron_trainer;

    localparam int NS  = 8;
    localparam int ME  = 3;
    localparam int SC  = 2;
    localparam int PER = SC + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [3:0] load_in1 = '0;
    logic [3:0] load_in2 = '0;
    logic [6:0] load_in3 = '0;
    logic       load_desired = 1'b0;
    logic       clear_samples = 1'b0;
    logic       start = 1'b0;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [6:0] in3;
    logic       desired_out;
    logic       perc_out = 1'b0;
    logic       busy;
    logic       done;
    logic       converged;
    logic [7:0] epoch_count;
    logic [4:0] error_count;
`ifdef TRAINER_STATS_EN
    logic [15:0] total_errors;
    logic [4:0]  last_epoch_errors;
`endif

    perceptron_trainer #(
        .NUM_SAMPLES   (NS),
        .MAX_EPOCHS    (ME),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_in1      (load_in1),
        .load_in2      (load_in2),
        .load_in3      (load_in3),
        .load_desired  (load_desired),
        .clear_samples (clear_samples),
        .start         (start),
        .in1           (in1),
        .in2           (in2),
        .in3           (in3),
        .desired_out   (desired_out),
        .perc_out      (perc_out),
        .busy          (busy),
        .done          (done),
        .converged     (converged),
        .epoch_count   (epoch_count),
        .error_count   (error_count)
`ifdef TRAINER_STATS_EN
        ,
        .total_errors      (total_errors),
        .last_epoch_errors (last_epoch_errors)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [6:0] c;
        logic       d;
    } smp_t;

    smp_t smp[$];
    int   nchk = 0;
    int   nerr = 0;
    // Perceptron stand-in: 0 = always right, 1 = stuck at 0, 2 = fixed threshold unit, 3 = wrong on odd in3.
    int   pmode = 0;
    int   w1 = 0, w2 = 0, w3 = 0, thr = 0;

    function automatic logic pfun(input logic [3:0] a, input logic [3:0] b, input logic [6:0] c);
        return (w1 * int'(a) + w2 * int'(b) + w3 * int'(c)) > thr;
    endfunction

    always @(posedge clk) begin
        case (pmode)
            0: perc_out <= desired_out;
            1: perc_out <= 1'b0;
            2: perc_out <= pfun(in1, in2, in3);
            default: perc_out <= desired_out ^ in3[0];
        endcase
    end

    function automatic logic wrong(input smp_t s);
        case (pmode)
            0: return 1'b0;
            1: return s.d;
            2: return pfun(s.a, s.b, s.c) != s.d;
            default: return s.c[0];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [3:0] b, input logic [6:0] c, input logic d);
        smp_t s;
        @(negedge clk);
        load_valid = 1'b1; load_in1 = a; load_in2 = b; load_in3 = c; load_desired = d;
        @(negedge clk);
        load_valid = 1'b0;
        s.a = a; s.b = b; s.c = c; s.d = d;
        if (smp.size() < NS) smp.push_back(s);
    endtask

    task automatic load_rand();
        load(4'($urandom), 4'($urandom), 7'($urandom), 1'($urandom));
    endtask

    task automatic clr();
        @(negedge clk); clear_samples = 1'b1;
        @(negedge clk); clear_samples = 1'b0;
        smp.delete();
    endtask

    // Runs one training pass; expectations come from the epoch rules applied to the sample list.
    task automatic run(input string tag, input int glitch_at);
        int n, m, runs, ep, ec, total, eplen, k, p;
        logic cv;
        logic [15:0] expv;
        n = smp.size();
        m = 0;
        foreach (smp[i]) if (wrong(smp[i])) m++;
        if (m == 0) begin runs = 1; ep = 0; cv = 1'b1; ec = 0; end
        else begin runs = ME; ep = ME; cv = 1'b0; ec = (m > 31) ? 31 : m; end
        eplen = n * PER + 1;
        total = runs * eplen;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        k = 0;
        while (!done && k < total + 50) begin
            p = k % eplen;
            if (p < n * PER && p % PER == 0) begin
                expv = {smp[p / PER].a, smp[p / PER].b, smp[p / PER].c, smp[p / PER].d};
                chk({tag, "_present"}, 32'({in1, in2, in3, desired_out}), 32'(expv));
                chk({tag, "_busy"}, 32'(busy), 32'd1);
            end
            start = (k == glitch_at);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        expv = {smp[n - 1].a, smp[n - 1].b, smp[n - 1].c, smp[n - 1].d};
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_cycles"}, 32'(k), 32'(total));
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_converged"}, 32'(converged), 32'(cv));
        chk({tag, "_epochs"}, 32'(epoch_count), 32'(ep));
        chk({tag, "_errors"}, 32'(error_count), 32'(ec));
        chk({tag, "_hold_last"}, 32'({in1, in2, in3, desired_out}), 32'(expv));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_conv", 32'(converged), 32'd0);
        chk("rst_epoch", 32'(epoch_count), 32'd0);
        chk("rst_err", 32'(error_count), 32'd0);
        chk("rst_outs", 32'({in1, in2, in3, desired_out}), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd1);
        reset = 1'b1;

        // Load boundary: eight accepted, ninth dropped, full epoch of eight
        pmode = 0;
        for (int i = 0; i < NS; i++) load_rand();
        chk("full_ready", 32'(load_ready), 32'd0);
        load(4'hF, 4'hF, 7'h7F, 1'b1);
        run("full8", -1);
        clr();
        chk("clear_ready", 32'(load_ready), 32'd1);

        // Convergence in first epoch with two samples
        load_rand(); load_rand();
        run("conv2", -1);

        // Timeout with perc_out stuck at 0
        clr();
        pmode = 1;
        load(4'd3, 4'd5, 7'd9, 1'b1);
        run("timeout", -1);

        // Start pulsed while busy must not disturb the run
        clr();
        load(4'd1, 4'd2, 7'd3, 1'b1);
        load_rand(); load_rand();
        run("glitch", 4);

        // Randomised sample sets against a fixed threshold unit
        pmode = 2;
        for (int r = 0; r < 5; r++) begin
            clr();
            w1 = int'($urandom_range(0, 7)); w2 = int'($urandom_range(0, 7));
            w3 = int'($urandom_range(0, 3)); thr = int'($urandom_range(0, 200));
            for (int i = 0, n = int'($urandom_range(1, NS)); i < n; i++) load_rand();
            run("rand", -1);
        end

        // Start with an empty memory is ignored and done holds
        clr();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_done", 32'(done), 32'd1);

`ifdef TRAINER_STATS_EN
        // Two mismatches in epoch one, then the perceptron becomes correct
        begin
            int k;
            pmode = 3;
            for (int i = 0; i < 4; i++) load(4'($urandom), 4'($urandom), 7'(i), 1'($urandom));
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            k = 0;
            while (!done && k < 100) begin
                if (k == 4 * PER + 1) begin
                    chk("stats_last1", 32'(last_epoch_errors), 32'd2);
                    chk("stats_epoch1", 32'(epoch_count), 32'd1);
                    pmode = 0;
                end
                @(negedge clk);
                k++;
            end
            chk("stats_cycles", 32'(k), 32'(2 * (4 * PER + 1)));
            chk("stats_total", 32'(total_errors), 32'd2);
            chk("stats_last2", 32'(last_epoch_errors), 32'd0);
            chk("stats_conv", 32'(converged), 32'd1);
            chk("stats_epochs", 32'(epoch_count), 32'd1);
        end
`endif

        // Asynchronous reset mid-run drops the run and the samples
        clr();
        pmode = 1;
        load(4'd7, 4'd7, 7'd7, 1'b1); load_rand(); load_rand();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_outs", 32'({in1, in2, in3, desired_out}), 32'd0);
        chk("mid_epoch_err", 32'({epoch_count, error_count}), 32'd0);
        chk("mid_ready", 32'(load_ready), 32'd1);
        @(negedge clk); reset = 1'b1;
        smp.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_start", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Training sequencer that sits directly upstream of the perceptron. It stores a small set of labelled samples and presents them one at a time on the perceptron's `in1`/`in2`/`in3`/`desired_out` inputs. It checks the perceptron's registered `out` for each sample and counts mismatches per epoch. It stops when an epoch completes with zero errors (converged) or when the epoch limit is reached.

## Interface

Parameters:
- `NUM_SAMPLES`, 8: sample memory depth; range 1..16.
- `MAX_EPOCHS`, 64: epoch limit; range 1..255.
- `SETTLE_CYCLES`, 2: cycles each sample is held before `perc_out` is checked; minimum 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `load_valid` in 1: sample write request.
- `load_ready` out 1: sample write can be accepted.
- `load_in1` in 4, `load_in2` in 4, `load_in3` in 7, `load_desired` in 1: sample fields.
- `clear_samples` in 1: empties the sample memory.
- `start` in 1: begin a training run.
- `in1` out 4, `in2` out 4, `in3` out 7, `desired_out` out 1: drive the perceptron.
- `perc_out` in 1: the perceptron's registered `out`.
- `busy` out 1: run in progress.
- `done` out 1: run finished; held high until the next start or reset.
- `converged` out 1: valid when `done` is high; 1 means the last epoch had zero errors.
- `epoch_count` out 8: number of completed epochs.
- `error_count` out 5: mismatches counted so far in the current epoch.

## Operation

- **States:** IDLE, PRESENT, CHECK, EPOCH_END, DONE.
- **Sample loading:**
  - `load_ready` = (state is IDLE or DONE) and `sample_count < NUM_SAMPLES`.
  - On `load_valid && load_ready`, the sample is written at index `sample_count`, then `sample_count` increments.
  - `clear_samples` in IDLE or DONE sets `sample_count` to 0. In other states it is ignored.
  - If `clear_samples` and a load handshake occur in the same cycle, the clear wins and the load is dropped.
- **Starting a run:**
  - `start` in IDLE or DONE with `sample_count > 0` goes to PRESENT. It sets index = 0 and clears `epoch_count`, `error_count`, `done` and `converged`.
  - `start` with `sample_count == 0` is ignored.
  - `start` while `busy` is ignored.
- **PRESENT:**
  - Drives sample[index] on `in1`/`in2`/`in3`/`desired_out`, registered.
  - The hold counter counts `SETTLE_CYCLES` cycles, then the block moves to CHECK.
- **CHECK (one cycle):**
  - If `perc_out != desired_out`, `error_count` increments. It saturates at 31.
  - If index == `sample_count - 1`, go to EPOCH_END. Otherwise index+1 and go to PRESENT.
- **EPOCH_END (one cycle):**
  - If `error_count == 0`: go to DONE with `converged` = 1.
  - Otherwise `epoch_count` increments. If the new value equals `MAX_EPOCHS`, go to DONE with `converged` = 0.
  - Otherwise clear `error_count`, set index = 0 and go to PRESENT.
- **DONE:** `done` = 1. The sample outputs keep their last values. `epoch_count` holds.
- **Status outputs:** `busy` = 1 in PRESENT, CHECK and EPOCH_END.
- **Arithmetic:** all counters are unsigned. `epoch_count` cannot exceed `MAX_EPOCHS`.

## Timing

- **Reset values:**
  - All outputs are 0: `in1`/`in2`/`in3`/`desired_out`, `busy`, `done`, `converged`, `epoch_count`, `error_count`.
  - `load_ready` is 1 after reset, because the state is IDLE and `sample_count` is 0.
  - State is IDLE and `sample_count` is 0; sample memory contents are don't-care.
- **Reset mid-run:** aborts the run immediately (asynchronous). All samples are lost.
- **Start latency:** `start` sampled at edge N gives `busy` = 1 and sample 0 on the outputs after edge N.
- **Per-sample period:** `SETTLE_CYCLES + 1` cycles. The perceptron registers `out` one edge after its inputs change, so `SETTLE_CYCLES >= 2` guarantees that `perc_out` reflects the current sample at CHECK.
- **Epoch period:** `sample_count × (SETTLE_CYCLES + 1) + 1` cycles.
- **End of run:** `done` rises on the edge leaving EPOCH_END. `busy` falls on the same edge.

## Configuration

- **`TRAINER_STATS_EN` defined:** adds two outputs.
  - `total_errors`, out 16: mismatches accumulated over the whole run; saturating; cleared on start.
  - `last_epoch_errors`, out 5: the `error_count` value latched at each EPOCH_END.
- **Not defined:** both ports and their registers are absent. All other behaviour is unchanged.

## Structure

- **Package `perceptron_trainer_pkg`:**
  - State enum `trainer_state_t`.
  - Field width constants: IN1_W = 4, IN2_W = 4, IN3_W = 7.
  - Packed sample struct `trainer_sample_t` (in1, in2, in3, desired).
- **Sub-module `trainer_sample_mem`:** register-file storage with one write port and one asynchronous read port, indexed by sample number.

## Test plan

- **Reset values:** reset asserted during a run with 3 samples loaded → all outputs 0 and `load_ready` = 1 immediately; a following `start` is ignored.
- **Load boundary:** load 8 samples with `NUM_SAMPLES` = 8 → `load_ready` drops after the 8th; a 9th `load_valid` is not written; `clear_samples` → `load_ready` = 1.
- **Convergence in first epoch:** 2 samples, `perc_out` model always matching `desired_out` → `done` = 1, `converged` = 1, `epoch_count` = 0 after 2×3+1 cycles.
- **Timeout:** `MAX_EPOCHS` = 3 and `perc_out` stuck at 0 with a sample whose desired = 1 → `done` = 1, `converged` = 0, `epoch_count` = 3.
- **Ignored start:** `start` pulsed while `busy` → sequence and counters unaffected.
- **Stats (`TRAINER_STATS_EN`):** 4 samples with 2 mismatching, then converging → `last_epoch_errors` = 2 after epoch 1; `total_errors` = 2 at `done`.
